// File: rtl/sprite_pkg.sv
// Shared types, command-word layout and the pattern table for the sprite layer.
package sprite_pkg;

    typedef struct packed {
        logic [15:0] base;
        logic [15:0] w;
        logic [15:0] h;
    } pattern_t;

    typedef struct packed {
        logic       vis;
        logic       flip;
        logic [4:0] pattern;
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] frame;
    } child_state_t;

    localparam int F_COMP  = 26;
    localparam int F_CHILD = 21;
    localparam int F_ACT   = 17;
    localparam int F_TYPE  = 14;
    localparam int F_BUF   = 13;

    localparam logic [3:0] ACT_SWAP  = 4'hF;
    localparam logic [3:0] ACT_WRITE = 4'h1;

    localparam logic [2:0] TY_VIS   = 3'b001;
    localparam logic [2:0] TY_X     = 3'b010;
    localparam logic [2:0] TY_Y     = 3'b011;
    localparam logic [2:0] TY_FRAME = 3'b100;
    localparam logic [2:0] TY_CLR   = 3'b101;

    // Square tile, and a half-height strip whose frames step through memory in 128-entry blocks.
    localparam pattern_t PAT_TILE  = '{base: 16'd0, w: 16'd16, h: 16'd16};
    localparam pattern_t PAT_STRIP = '{base: 16'd0, w: 16'd16, h: 16'd8};

    function automatic pattern_t get_pattern(input logic [4:0] idx);
        pattern_t p;
        case (idx)
            5'd0:    p = PAT_TILE;
            5'd1:    p = PAT_STRIP;
            default: p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sprite_layer_display_if.sv
// Command and raster bus between the host/VGA timing and the sprite layer.
interface sprite_layer_display_if;
    logic        write;
    logic [31:0] writedata;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [23:0] RGB_output;
    logic        cmd_drop;

    modport master (
        output write, writedata, hcount, vcount,
        input  RGB_output, cmd_drop
    );

    modport slave (
        input  write, writedata, hcount, vcount,
        output RGB_output, cmd_drop
    );
endinterface

// File: rtl/sprite_layer_display_addr_gen.sv
// Per-child hit test and pixel-memory address for the current raster position.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int MEM_DEPTH = 384,
    parameter int AW        = 9
) (
    input  child_state_t   st,
    input  logic [9:0]     hcount,
    input  logic [9:0]     vcount,
    output logic           hit,
    output logic [AW-1:0]  addr
);

    pattern_t    pat;
    logic [16:0] h_ext, v_ext, x_ext, y_ext, x_end, y_end;
    logic [15:0] dx, dy, col;
    logic [39:0] full_addr;
    logic        in_box;

    always_comb begin
        pat   = get_pattern(st.pattern);
        h_ext = {7'd0, hcount};
        v_ext = {7'd0, vcount};
        x_ext = {7'd0, st.x};
        y_ext = {7'd0, st.y};
        // Widened so a sprite near column/row 1023 cannot wrap back to zero.
        x_end = x_ext + {1'b0, pat.w};
        y_end = y_ext + {1'b0, pat.h};
        in_box = st.vis && (h_ext >= x_ext) && (h_ext < x_end)
                        && (v_ext >= y_ext) && (v_ext < y_end);
        dx  = {6'd0, hcount} - {6'd0, st.x};
        dy  = {6'd0, vcount} - {6'd0, st.y};
        col = st.flip ? (pat.w - 16'd1 - dx) : dx;
        full_addr = 40'(pat.base)
                  + 40'(st.frame) * 40'(pat.w) * 40'(pat.h)
                  + 40'(dy) * 40'(pat.w)
                  + 40'(col);
        hit  = in_box && (full_addr < 40'(MEM_DEPTH));
        addr = full_addr[AW-1:0];
    end

endmodule

// File: rtl/sprite_layer_display.sv
// Double-buffered sprite layer: command decode, frame-boundary buffer swap, 2-clk pixel pipeline.
module sprite_layer_display
    import sprite_pkg::*;
#(
    parameter logic [5:0]  COMPONENT_ID    = 6'd5,
    parameter int          CHILD_LIMIT     = 4,
    parameter int          PATTERN_COUNT   = 2,
    parameter int          PIXEL_BITS      = 2,
    parameter int          MEM_DEPTH       = 384,
    parameter string       MEM_FILE        = "sprite.txt",
    parameter int          TRANSPARENT_IDX = 0,
    parameter logic [23:0] BG_COLOR        = 24'h202020,
    parameter logic [9:0]  SWAP_LINE       = 10'd480
) (
    input logic clk,
    input logic reset,
    sprite_layer_display_if.slave bus
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = (CHILD_LIMIT > 1) ? $clog2(CHILD_LIMIT) : 1;
    localparam logic [PIXEL_BITS-1:0] TRANSP = PIXEL_BITS'(TRANSPARENT_IDX);

    child_state_t buf_st [2][CHILD_LIMIT];
    child_state_t disp_st [CHILD_LIMIT];
    logic active_sel, swap_pending, pending_sel;

    logic [5:0]  cmd_comp;
    logic [4:0]  cmd_child;
    logic [3:0]  cmd_act;
    logic [2:0]  cmd_type;
    logic        cmd_buf;
    logic [12:0] cmd_data;
    logic [CW-1:0] child_idx;
    logic        unused_data_bit;
    logic        swap_apply, swap_req, eff_active, wr_hit, wr_drop, wr_accept, pat_ok;

    logic [CHILD_LIMIT-1:0] hit_p0, hit_p1;
    logic [AW-1:0]          addr_p0 [CHILD_LIMIT];
    logic [PIXEL_BITS-1:0]  pix_p1 [CHILD_LIMIT];
    logic                   win_found;
    logic [PIXEL_BITS-1:0]  win_idx;
    logic [23:0]            rgb_p2;
    logic                   drop_p1;

    // Pixel memory contents: each 2-bit slice of the address is summed, plus one, modulo 4.
    function automatic logic [PIXEL_BITS-1:0] pixel_mem(input logic [AW-1:0] a);
        logic [AW:0] ext;
        logic [1:0]  sum;
        ext = {1'b0, a};
        sum = 2'd1;
        for (int i = 0; i < AW; i += 2) sum = sum + ext[i +: 2];
        return PIXEL_BITS'(sum);
    endfunction

    function automatic logic [23:0] palette(input logic [PIXEL_BITS-1:0] idx);
        case (int'(idx))
            0:       return BG_COLOR;
            1:       return 24'hE04040;
            2:       return 24'h40E040;
            3:       return 24'h4040E0;
            default: return {3{8'(idx)}};
        endcase
    endfunction

    assign cmd_comp        = bus.writedata[F_COMP +: 6];
    assign cmd_child       = bus.writedata[F_CHILD +: 5];
    assign cmd_act         = bus.writedata[F_ACT +: 4];
    assign cmd_type        = bus.writedata[F_TYPE +: 3];
    assign cmd_buf         = bus.writedata[F_BUF];
    assign cmd_data        = bus.writedata[12:0];
    assign child_idx       = cmd_child[CW-1:0];
    assign unused_data_bit = cmd_data[10];

    always_comb begin
        swap_apply = swap_pending && (bus.hcount == 10'd0) && (bus.vcount == SWAP_LINE);
        // A write on the swap cycle is judged against the buffer about to be displayed.
        eff_active = swap_apply ? pending_sel : active_sel;
        swap_req   = bus.write && (cmd_act == ACT_SWAP);
        wr_hit     = bus.write && (cmd_act == ACT_WRITE) && (cmd_comp == COMPONENT_ID)
                     && (int'(cmd_child) < CHILD_LIMIT);
        wr_drop    = wr_hit && (cmd_buf == eff_active);
        wr_accept  = wr_hit && !wr_drop;
        pat_ok     = int'(cmd_data[4:0]) < PATTERN_COUNT;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active_sel   <= 1'b0;
            swap_pending <= 1'b0;
            pending_sel  <= 1'b0;
            drop_p1      <= 1'b0;
            for (int b = 0; b < 2; b++)
                for (int c = 0; c < CHILD_LIMIT; c++) buf_st[b][c].vis <= 1'b0;
        end else begin
            drop_p1 <= wr_drop;
            if (swap_apply) begin
                active_sel   <= pending_sel;
                swap_pending <= 1'b0;
                for (int c = 0; c < CHILD_LIMIT; c++) buf_st[~pending_sel][c].vis <= 1'b0;
            end
            if (swap_req) begin
                swap_pending <= 1'b1;
                pending_sel  <= cmd_buf;
            end
            // Placed after the swap clear so a same-cycle write to that buffer wins.
            if (wr_accept) begin
                case (cmd_type)
                    TY_VIS: begin
                        buf_st[cmd_buf][child_idx].vis  <= cmd_data[12];
                        buf_st[cmd_buf][child_idx].flip <= cmd_data[11];
                        if (pat_ok) buf_st[cmd_buf][child_idx].pattern <= cmd_data[4:0];
                    end
                    TY_X:     buf_st[cmd_buf][child_idx].x     <= cmd_data[9:0];
                    TY_Y:     buf_st[cmd_buf][child_idx].y     <= cmd_data[9:0];
                    TY_FRAME: buf_st[cmd_buf][child_idx].frame <= cmd_data[3:0];
                    TY_CLR: begin
                        for (int c = 0; c < CHILD_LIMIT; c++) buf_st[cmd_buf][c].vis <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage 0: combinational hit/address per child from the displayed buffer
    for (genvar c = 0; c < CHILD_LIMIT; c++) begin : g_child
        assign disp_st[c] = buf_st[active_sel][c];
        sprite_addr_gen #(
            .MEM_DEPTH (MEM_DEPTH),
            .AW        (AW)
        ) u_addr (
            .st     (disp_st[c]),
            .hcount (bus.hcount),
            .vcount (bus.vcount),
            .hit    (hit_p0[c]),
            .addr   (addr_p0[c])
        );
    end

    // Stage 1: one synchronous memory read per child, hit registered alongside
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHILD_LIMIT; c++) pix_p1[c] <= pixel_mem(addr_p0[c]);
    end

    always_ff @(posedge clk) begin
        if (!reset) hit_p1 <= '0;
        else        hit_p1 <= hit_p0;
    end

    // Stage 2: priority resolve, lowest opaque child wins
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int c = CHILD_LIMIT - 1; c >= 0; c--) begin
            if (hit_p1[c] && (pix_p1[c] != TRANSP)) begin
                win_found = 1'b1;
                win_idx   = pix_p1[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)         rgb_p2 <= BG_COLOR;
        else if (win_found) rgb_p2 <= palette(win_idx);
        else                rgb_p2 <= BG_COLOR;
    end

    assign bus.RGB_output = rgb_p2;
    assign bus.cmd_drop   = drop_p1;

endmodule

// File: tb/tb_sprite_layer_display.sv
// Scoreboard bench for sprite_layer_display: pixels predicted per cycle, compared 2 clk later.
`timescale 1ns/1ps
module tb_sprite_layer_display;

    localparam logic [23:0] BG = 24'h202020;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sprite_layer_display_if bus();

    sprite_layer_display dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { bit vis; bit flip; int pat; int x; int y; int frame; } mchild_t;
    typedef struct { logic [23:0] rgb; int due; int h; int v; } exp_t;

    mchild_t mb [2][4];
    bit      m_active, m_pend, m_psel;
    exp_t    sbq [$];
    int      cyc, n_chk, n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int mem_val(input int a);
        int s;
        s = 1;
        for (int i = 0; i < 9; i += 2) s += (a >> i) & 3;
        return s % 4;
    endfunction

    function automatic logic [23:0] pal(input int i);
        case (i)
            1:       return 24'hE04040;
            2:       return 24'h40E040;
            3:       return 24'h4040E0;
            default: return BG;
        endcase
    endfunction

    function automatic logic [23:0] model_pixel(input int h, input int v);
        mchild_t s;
        int w, ht, col, a;
        for (int c = 0; c < 4; c++) begin
            s  = mb[m_active][c];
            w  = 16;
            ht = (s.pat == 1) ? 8 : 16;
            if (s.vis && h >= s.x && h < s.x + w && v >= s.y && v < s.y + ht) begin
                col = s.flip ? (w - 1 - (h - s.x)) : (h - s.x);
                a   = s.frame * w * ht + (v - s.y) * w + col;
                if (a < 384 && mem_val(a) != 0) return pal(mem_val(a));
            end
        end
        return BG;
    endfunction

    function automatic logic [31:0] cmd(input int comp, input int child, input int act,
                                        input int ty, input int b, input int data);
        return {6'(comp), 5'(child), 4'(act), 3'(ty), 1'(b), 13'(data)};
    endfunction

    task automatic cycle(input int h, input int v, input bit wr, input logic [31:0] wd);
        logic [5:0]  comp;
        logic [3:0]  act;
        logic [2:0]  ty;
        logic [12:0] d;
        int          child;
        bit          b, apply, eff, drop, ok;
        exp_t        e;
        bus.hcount    = 10'(h);
        bus.vcount    = 10'(v);
        bus.write     = wr;
        bus.writedata = wd;
        sbq.push_back('{rgb: model_pixel(h, v), due: cyc + 2, h: h, v: v});
        comp  = wd[31:26];
        child = int'(wd[25:21]);
        act   = wd[20:17];
        ty    = wd[16:14];
        b     = wd[13];
        d     = wd[12:0];
        apply = m_pend && h == 0 && v == 480;
        eff   = apply ? m_psel : m_active;
        ok    = wr && act == 4'h1 && comp == 6'd5 && child < 4;
        drop  = ok && b == eff;
        if (apply) begin
            for (int c = 0; c < 4; c++) mb[!m_psel][c].vis = 1'b0;
            m_active = m_psel;
            m_pend   = 1'b0;
        end
        if (wr && act == 4'hF) begin
            m_pend = 1'b1;
            m_psel = b;
        end
        if (ok && !drop) begin
            case (ty)
                3'd1: begin
                    mb[b][child].vis  = d[12];
                    mb[b][child].flip = d[11];
                    if (int'(d[4:0]) < 2) mb[b][child].pat = int'(d[4:0]);
                end
                3'd2: mb[b][child].x     = int'(d[9:0]);
                3'd3: mb[b][child].y     = int'(d[9:0]);
                3'd4: mb[b][child].frame = int'(d[3:0]);
                3'd5: for (int c = 0; c < 4; c++) mb[b][c].vis = 1'b0;
                default: ;
            endcase
        end
        @(posedge clk);
        #1;
        cyc++;
        check("cmd_drop", bus.cmd_drop, drop);
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            check($sformatf("rgb(%0d,%0d)", e.h, e.v), bus.RGB_output, e.rgb);
        end
    endtask

    task automatic wr(input logic [31:0] w);
        cycle(600, 400, 1'b1, w);
    endtask

    task automatic set_child(input int b, input int c, input int vis, input int flip,
                             input int pat, input int x, input int y, input int frame);
        wr(cmd(5, c, 1, 2, b, x));
        wr(cmd(5, c, 1, 3, b, y));
        wr(cmd(5, c, 1, 4, b, frame));
        wr(cmd(5, c, 1, 1, b, (vis << 12) | (flip << 11) | pat));
    endtask

    task automatic scan(input int v, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) cycle(x, v, 1'b0, 32'd0);
    endtask

    task automatic swap_now(input int b);
        wr(cmd(0, 0, 15, 0, b, 0));
        cycle(0, 480, 1'b0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        cyc   = 0;
        bus.hcount = '0;
        bus.vcount = '0;
        bus.write  = 1'b0;
        bus.writedata = '0;
        // Reset held for two edges while random commands are presented
        reset = 1'b0;
        repeat (2) begin
            bus.write     = 1'b1;
            bus.writedata = $urandom;
            @(posedge clk);
            #1;
            check("rst_rgb", bus.RGB_output, BG);
            check("rst_drop", bus.cmd_drop, 1'b0);
        end
        reset     = 1'b1;
        bus.write = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 4; c++) mb[b][c] = '{0, 0, 0, 0, 0, 0};
        m_active = 0;
        m_pend   = 0;
        m_psel   = 0;

        scan(50, 96, 120);

        // First sprite on buffer 1, made visible at the frame boundary
        set_child(1, 0, 1, 0, 0, 100, 50, 0);
        wr(cmd(0, 0, 15, 0, 1, 0));
        scan(50, 98, 104);
        cycle(0, 480, 1'b0, 32'd0);
        scan(50, 98, 118);
        scan(65, 98, 118);
        scan(66, 98, 102);

        // Horizontal flip
        set_child(0, 0, 1, 1, 0, 100, 50, 0);
        swap_now(0);
        scan(50, 98, 118);
        scan(51, 98, 118);

        // Animation frames of the strip pattern; frame 3 lies past the memory end
        set_child(1, 0, 1, 0, 1, 200, 100, 1);
        set_child(1, 1, 1, 0, 1, 240, 100, 2);
        set_child(1, 2, 1, 0, 1, 280, 100, 3);
        wr(cmd(5, 0, 1, 1, 1, (1 << 12) | 7));
        swap_now(1);
        scan(100, 198, 300);
        scan(107, 198, 260);
        scan(108, 198, 220);

        // Overlap with transparency fall-through; child 2 staged invisible
        set_child(0, 0, 1, 0, 0, 300, 300, 0);
        set_child(0, 1, 1, 0, 0, 302, 300, 0);
        set_child(0, 2, 0, 0, 0, 500, 200, 0);
        swap_now(0);
        scan(300, 296, 320);
        scan(303, 296, 320);

        // Dropped and ignored writes
        wr(cmd(5, 0, 1, 2, 0, 10));
        wr(cmd(5, 4, 1, 2, 0, 10));
        wr(cmd(6, 0, 1, 2, 0, 10));
        wr(cmd(5, 0, 1, 6, 1, 10));
        scan(300, 296, 320);
        set_child(1, 3, 1, 0, 0, 400, 200, 0);
        wr(cmd(5, 0, 1, 5, 1, 0));
        set_child(1, 3, 1, 0, 0, 400, 200, 0);

        // Mid-frame request; repeated request overwrites the target buffer
        cycle(410, 200, 1'b1, cmd(0, 0, 15, 0, 1, 0));
        wr(cmd(0, 0, 15, 0, 0, 0));
        wr(cmd(0, 0, 15, 0, 1, 0));
        scan(200, 396, 420);
        scan(300, 296, 310);
        cycle(0, 480, 1'b1, cmd(5, 2, 1, 1, 0, 1 << 12));
        scan(200, 396, 420);
        swap_now(0);
        scan(300, 296, 320);
        scan(200, 496, 520);

        cycle(600, 400, 1'b0, 32'd0);
        cycle(600, 400, 1'b0, 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sprite_layer_display.md
Name: sprite_layer_display

Overview:
- Parametrised successor to the single-type sprite display blocks. Renders up to CHILD_LIMIT instances of one sprite family into the VGA pixel stream.
- Command words use the shared writedata format and are qualified by a write strobe.
- Sprite state is double-buffered; buffer swaps take effect only at a frame boundary.
- Adds per-child horizontal flip, animation frame select, transparency fall-through to lower-priority children, and a registered, fixed-latency pixel pipeline.
- Sits beside the other *_display blocks; its RGB output feeds the top-level layer mux.

Parameters:
- COMPONENT_ID, 6'd5, component field value this block answers to.
- CHILD_LIMIT, 4, number of sprite instances (1..32).
- PATTERN_COUNT, 2, number of entries in the pattern table.
- PIXEL_BITS, 2, bits per pixel palette index.
- MEM_DEPTH, 384, pixel memory entries.
- MEM_FILE, "sprite.txt", $readmemh init file.
- TRANSPARENT_IDX, 0, palette index treated as see-through.
- BG_COLOR, 24'h202020, output when no child is opaque.
- SWAP_LINE, 10'd480, vcount at which a pending swap is applied.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- write  in  1  strobe; writedata is decoded only when write=1.
- writedata  in  32  command word.
- hcount  in  10  current pixel column.
- vcount  in  10  current pixel row.
- RGB_output  out  24  pixel colour, 2 clk after hcount/vcount.
- cmd_drop  out  1  one-cycle pulse when an accepted-ID write targets the displayed buffer.

Interface decided: one clock (clk); reset is synchronous and active-low (reset).

Behaviour:
- Command field decode: [31:26] component, [25:21] child, [20:17] action, [16:14] type, [13] buf, [12:0] data.
- Reset (reset=0 at a clk edge):
  - active_sel=0 and swap_pending=0.
  - All visibility bits in both buffers cleared; all other state fields are don't-care.
  - Pipeline valid bits cleared; RGB_output=BG_COLOR and cmd_drop=0 from the next cycle.
- action 4'hF (any component):
  - Sets swap_pending=1 and pending_sel=buf.
  - A repeated request before the swap is applied overwrites pending_sel.
- Swap apply: on the cycle where swap_pending=1, hcount=0 and vcount=SWAP_LINE:
  - active_sel<=pending_sel and swap_pending<=0.
  - Visibility of every child in buffer ~pending_sel is cleared.
- action 4'h1, component==COMPONENT_ID, child<CHILD_LIMIT:
  - If buf==active_sel (after any same-cycle swap), the write is dropped and cmd_drop pulses.
  - Otherwise the write updates back-buffer child state by type:
    - 001: vis=data[12], flip=data[11], pattern=data[4:0]. The pattern field is written only if data[4:0]<PATTERN_COUNT; vis and flip are always written.
    - 010: x=data[9:0].
    - 011: y=data[9:0].
    - 100: frame=data[3:0].
    - 101: clear visibility of all children in buffer buf.
    - Other types: ignored.
- Same cycle as a swap apply: a write to the buffer being cleared wins for the fields it writes.
- child>=CHILD_LIMIT or a foreign component: no effect, no cmd_drop.
- Stage 0 (combinational, per child, from the active buffer):
  - Hit when vis=1 and x<=hcount<x+w and y<=vcount<y+h. Compare in 11 bits so there is no wrap near 1023.
  - dx=hcount-x, dy=vcount-y; col = flip ? w-1-dx : dx.
  - addr = base + frame*w*h + dy*w + col.
  - If addr>=MEM_DEPTH, hit is forced to 0.
- Stage 1 (registered):
  - The pixel memory is replicated once per child, with a synchronous read.
  - The hit bit is registered alongside each read.
- Stage 2 (registered RGB_output):
  - The lowest-index child with hit=1 and pixel index!=TRANSPARENT_IDX wins.
  - RGB_output=palette[index]; if no child wins, RGB_output=BG_COLOR.
- Total latency from hcount/vcount to RGB_output: exactly 2 clk.
- The palette is a constant array (entry 0 = BG_COLOR); it is not writable.

Decomposition:
- sprite_pkg holds:
  - pattern_t {base 16b, w 16b, h 16b} and this family's pattern table.
  - Command field bit positions and action/type codes (ACT_SWAP=4'hF, ACT_WRITE=4'h1, TY_VIS..TY_CLR).
  - child_state_t {vis, flip, pattern 5b, x 10b, y 10b, frame 4b}.
- Sub-module sprite_addr_gen (one per child) performs the stage-0 hit test and address generation.

Test Plan:
- Reset held low 2 clk with random writedata -> RGB_output=24'h202020, cmd_drop=0, no child visible after release.
- Write buf=1 child0: vis=1, pattern0, x=100, y=50. Issue swap (4'hF, buf=1) and run to vcount=480,hcount=0 -> next frame pixel (100,50) shows palette[mem[0]] 2 clk later; pixel (116,50) is BG.
- Child0 flip=1 at x=100 -> pixel (100,y) equals the unflipped pixel at (115,y); frame=1 with pattern1 -> addr offset 128.
- Children 0 and 1 overlap; child0 pixel index=TRANSPARENT_IDX, child1 opaque -> child1 colour. Child0 opaque -> child0 colour.
- Write with buf==active_sel -> cmd_drop=1 for one cycle, displayed image unchanged. child=CHILD_LIMIT -> no effect, no drop.
- Swap requested mid-frame at vcount=200 -> image unchanged until vcount=480,hcount=0. Old front buffer visibility reads 0 afterward. A write issued on the apply cycle survives.
